// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit owning the HI/LO pair (MULT, MULTU, DIV, DIVU, MTHI/MTLO).
// Define MDU_FAST_MULT_EN to replace the iterative multiply with a single-cycle product.
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 6
) (
    input  logic             iCLK,
    input  logic             iRSTn,
    input  logic             iStart,
    input  logic [1:0]       iOp,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    input  logic             iWrHi,
    input  logic             iWrLo,
    input  logic [WIDTH-1:0] iWrData,
    output logic [WIDTH-1:0] oHi,
    output logic [WIDTH-1:0] oLo,
    output logic             oBusy,
    output logic             oDone,
    output logic             oDivZero
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    localparam logic [CNTW-1:0] LAST_CNT = CNTW'(WIDTH - 1);

`ifdef MDU_FAST_MULT_EN
    localparam bit FAST_MULT = 1'b1;
`else
    localparam bit FAST_MULT = 1'b0;
`endif

    function automatic logic [WIDTH-1:0] cond_neg_w(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg_d(input logic [2*WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    logic [1:0]       state;
    logic [CNTW-1:0]  cnt;
    logic             op_div;
    logic             sign_a;
    logic             sign_b;
    logic             div_zero;
    logic [WIDTH-1:0] opnd;      // multiplicand or divisor magnitude
    logic [WIDTH:0]   acc_hi;    // product high word / remainder with borrow guard
    logic [WIDTH-1:0] acc_lo;    // multiplier shifting out / quotient shifting in
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             done;
    logic             dz_pulse;

    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic                    op_signed;
    logic                    neg_a;
    logic                    neg_b;
    logic [WIDTH-1:0]        abs_a;
    logic [WIDTH-1:0]        abs_b;
    logic                    start_dz;
    logic                    skip_calc;

    assign a_s       = iA;
    assign b_s       = iB;
    assign op_signed = ~iOp[0];
    assign neg_a     = op_signed & (a_s < 0);
    assign neg_b     = op_signed & (b_s < 0);
    assign abs_a     = cond_neg_w(iA, neg_a);
    assign abs_b     = cond_neg_w(iB, neg_b);
    assign start_dz  = iOp[1] && (iB == '0);
    assign skip_calc = start_dz || (FAST_MULT && !iOp[1]);

    // One iteration: shift-add for multiply, restoring shift-subtract for divide
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic [WIDTH:0]   calc_hi;
    logic [WIDTH-1:0] calc_lo;

    always_comb begin
        mul_sum   = acc_hi + (acc_lo[0] ? {1'b0, opnd} : '0);
        div_shift = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd};
        calc_hi   = acc_hi;
        calc_lo   = acc_lo;
        if (op_div) begin
            if (div_diff[WIDTH]) begin
                calc_hi = div_shift;
                calc_lo = {acc_lo[WIDTH-2:0], 1'b0};
            end else begin
                calc_hi = div_diff;
                calc_lo = {acc_lo[WIDTH-2:0], 1'b1};
            end
        end else begin
            calc_hi = {1'b0, mul_sum[WIDTH:1]};
            calc_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end
    end

    logic [2*WIDTH-1:0] mul_raw;
`ifdef MDU_FAST_MULT_EN
    assign mul_raw = {{WIDTH{1'b0}}, opnd} * {{WIDTH{1'b0}}, acc_lo};
`else
    assign mul_raw = {acc_hi[WIDTH-1:0], acc_lo};
`endif

    // Sign correction applied on the FIX edge
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign prod_fix = cond_neg_d(mul_raw, sign_a ^ sign_b);
    assign quot_fix = cond_neg_w(acc_lo, sign_a ^ sign_b);
    assign rem_fix  = cond_neg_w(acc_hi[WIDTH-1:0], sign_a);

    always_ff @(posedge iCLK) begin
        if (!iRSTn) begin
            state    <= S_IDLE;
            cnt      <= '0;
            op_div   <= 1'b0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            div_zero <= 1'b0;
            opnd     <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            dz_pulse <= 1'b0;
        end else begin
            done     <= 1'b0;
            dz_pulse <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (iWrHi) hi <= iWrData;
                    if (iWrLo) lo <= iWrData;
                    if (iStart) begin
                        op_div   <= iOp[1];
                        sign_a   <= neg_a;
                        sign_b   <= neg_b;
                        div_zero <= start_dz;
                        cnt      <= '0;
                        acc_hi   <= '0;
                        if (iOp[1]) begin
                            opnd   <= abs_b;
                            acc_lo <= abs_a;
                        end else begin
                            opnd   <= abs_a;
                            acc_lo <= abs_b;
                        end
                        state <= skip_calc ? S_FIX : S_CALC;
                    end
                end
                S_CALC: begin
                    acc_hi <= calc_hi;
                    acc_lo <= calc_lo;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST_CNT) state <= S_FIX;
                end
                S_FIX: begin
                    state <= S_IDLE;
                    done  <= 1'b1;
                    if (div_zero) begin
                        dz_pulse <= 1'b1;
                    end else if (op_div) begin
                        lo <= quot_fix;
                        hi <= rem_fix;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign oHi      = hi;
    assign oLo      = lo;
    assign oBusy    = (state != S_IDLE);
    assign oDone    = done;
    assign oDivZero = dz_pulse;

endmodule

// File: tb/tb_mult_div_unit.sv
// Testbench for mult_div_unit: directed and random operations checked against an arithmetic reference model.
module tb_mult_div_unit;

    localparam int W = 32;

    logic         iCLK = 1'b0;
    logic         iRSTn;
    logic         iStart;
    logic [1:0]   iOp;
    logic [W-1:0] iA;
    logic [W-1:0] iB;
    logic         iWrHi;
    logic         iWrLo;
    logic [W-1:0] iWrData;
    logic [W-1:0] oHi;
    logic [W-1:0] oLo;
    logic         oBusy;
    logic         oDone;
    logic         oDivZero;

    mult_div_unit #(.WIDTH(W), .CNTW(6)) dut (
        .iCLK(iCLK), .iRSTn(iRSTn), .iStart(iStart), .iOp(iOp), .iA(iA), .iB(iB),
        .iWrHi(iWrHi), .iWrLo(iWrLo), .iWrData(iWrData),
        .oHi(oHi), .oLo(oLo), .oBusy(oBusy), .oDone(oDone), .oDivZero(oDivZero)
    );

    always #5 iCLK = ~iCLK;

    int vectors = 0;
    int miscompares = 0;
    logic [W-1:0] m_hi;
    logic [W-1:0] m_lo;

`ifdef MDU_FAST_MULT_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the HI/LO architectural state
    task automatic model_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                            output bit dz);
        longint sa, sb;
        logic [63:0] p;
        dz = 1'b0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'd0: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
            2'd1: begin p = {32'b0, a} * {32'b0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
            2'd2: if (b == 0) dz = 1'b1; else begin m_lo = 32'(sa / sb); m_hi = 32'(sa % sb); end
            default: if (b == 0) dz = 1'b1; else begin m_lo = a / b; m_hi = a % b; end
        endcase
    endtask

    task automatic run_op(input string name, input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input bit collide);
        bit dz;
        int edges, busy_n, exp_edges;
        bit held;
        logic [W-1:0] prev_hi, prev_lo;
        prev_hi = m_hi;
        prev_lo = m_lo;
        model_op(op, a, b, dz);
        exp_edges = (dz || (FAST && !op[1])) ? 2 : 34;
        @(negedge iCLK);
        iOp = op; iA = a; iB = b; iStart = 1'b1;
        @(posedge iCLK); #1;
        iStart = 1'b0;
        edges = 1; busy_n = 0; held = 1'b1;
        while (!oDone && edges < 100) begin
            if (oBusy) busy_n++;
            if (oHi !== prev_hi || oLo !== prev_lo) held = 1'b0;
            if (collide && edges == 5) begin
                iStart = 1'b1; iOp = ~op; iA = $urandom; iB = $urandom;
                iWrLo = 1'b1; iWrHi = 1'b1; iWrData = $urandom;
            end else begin
                iStart = 1'b0; iWrLo = 1'b0; iWrHi = 1'b0;
            end
            @(posedge iCLK); #1;
            edges++;
        end
        iStart = 1'b0; iWrLo = 1'b0; iWrHi = 1'b0;
        check({name, ".latency"}, 64'(edges), 64'(exp_edges));
        check({name, ".busy_cycles"}, 64'(busy_n), 64'(exp_edges - 1));
        check({name, ".hold"}, 64'(held), 64'd1);
        check({name, ".divzero"}, 64'(oDivZero), 64'(dz));
        check({name, ".hi"}, 64'(oHi), 64'(m_hi));
        check({name, ".lo"}, 64'(oLo), 64'(m_lo));
        @(posedge iCLK); #1;
        check({name, ".done_once"}, 64'(oDone), 64'd0);
        check({name, ".idle_after"}, 64'(oBusy), 64'd0);
    endtask

    task automatic write_hilo(input bit to_hi, input logic [W-1:0] d);
        @(negedge iCLK);
        iWrHi = to_hi; iWrLo = ~to_hi; iWrData = d;
        @(posedge iCLK); #1;
        iWrHi = 1'b0; iWrLo = 1'b0;
        if (to_hi) m_hi = d; else m_lo = d;
        check(to_hi ? "mthi" : "mtlo", 64'(to_hi ? oHi : oLo), 64'(d));
    endtask

    initial begin
        int seen_done;
        iRSTn = 1'b0; iStart = 1'b0; iOp = '0; iA = '0; iB = '0;
        iWrHi = 1'b0; iWrLo = 1'b0; iWrData = '0;
        repeat (2) @(posedge iCLK);
        #1;
        m_hi = '0; m_lo = '0;
        check("rst.hi", 64'(oHi), 64'd0);
        check("rst.lo", 64'(oLo), 64'd0);
        check("rst.busy", 64'(oBusy), 64'd0);
        check("rst.done", 64'(oDone), 64'd0);
        check("rst.divzero", 64'(oDivZero), 64'd0);
        iRSTn = 1'b1;

        run_op("mult_neg", 2'd0, 32'hFFFFFFFE, 32'h00000003, 1'b0);
        check("mult_neg.hi_const", 64'(oHi), 64'hFFFFFFFF);
        check("mult_neg.lo_const", 64'(oLo), 64'hFFFFFFFA);
        run_op("multu_max", 2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        check("multu_max.hi_const", 64'(oHi), 64'hFFFFFFFE);
        check("multu_max.lo_const", 64'(oLo), 64'h00000001);
        run_op("div_neg", 2'd2, 32'hFFFFFFF9, 32'h00000002, 1'b0);
        check("div_neg.lo_const", 64'(oLo), 64'hFFFFFFFD);
        check("div_neg.hi_const", 64'(oHi), 64'hFFFFFFFF);
        run_op("divu_100_7", 2'd3, 32'd100, 32'd7, 1'b0);
        check("divu_100_7.lo_const", 64'(oLo), 64'd14);
        check("divu_100_7.hi_const", 64'(oHi), 64'd2);
        run_op("div_ovf", 2'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        check("div_ovf.lo_const", 64'(oLo), 64'h80000000);
        check("div_ovf.hi_const", 64'(oHi), 64'd0);
        run_op("div_rem_sign", 2'd2, 32'd7, 32'hFFFFFFFE, 1'b0);

        write_hilo(1'b1, 32'h1234);
        write_hilo(1'b0, 32'h5678);
        run_op("div_zero", 2'd2, 32'd5, 32'd0, 1'b0);
        check("div_zero.hi_const", 64'(oHi), 64'h1234);
        check("div_zero.lo_const", 64'(oLo), 64'h5678);

        run_op("collide_divu", 2'd3, 32'hDEADBEEF, 32'h00001234, 1'b1);
        run_op("collide_mult", 2'd0, 32'h12345678, 32'hFEDCBA98, 1'b1);

        // Abort a divide with reset at cycle 10
        @(negedge iCLK);
        iOp = 2'd2; iA = 32'd1000; iB = 32'd3; iStart = 1'b1;
        @(posedge iCLK); #1;
        iStart = 1'b0;
        repeat (9) @(posedge iCLK);
        @(negedge iCLK);
        iRSTn = 1'b0;
        @(posedge iCLK); #1;
        iRSTn = 1'b1;
        m_hi = '0; m_lo = '0;
        check("abort.busy", 64'(oBusy), 64'd0);
        check("abort.hi", 64'(oHi), 64'd0);
        check("abort.lo", 64'(oLo), 64'd0);
        seen_done = 0;
        repeat (40) begin
            @(posedge iCLK); #1;
            if (oDone) seen_done++;
        end
        check("abort.no_done", 64'(seen_done), 64'd0);

        for (int i = 0; i < 30; i++) begin
            logic [1:0] op;
            logic [W-1:0] a, b;
            op = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 7) == 0) b = '0;
            else if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 15));
            run_op("random", op, a, b, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit that owns the HI/LO register pair.
- Sits directly downstream of the ALU control decoder, alongside the ALU.
- Executes the MULT, MULTU, DIV and DIVU control codes produced by that decoder, and services MTHI/MTLO writes and MFHI/MFLO reads.
- Asserts a busy stall toward the pipeline control while an operation is in flight.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNTW, 6, iteration counter width; must satisfy 2^CNTW > WIDTH.

Ports:
- iCLK  in  1  core clock
- iRSTn  in  1  synchronous reset, active-low
- iStart  in  1  start request, one cycle; sampled only in IDLE
- iOp  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- iA  in  WIDTH  rs operand (multiplicand / dividend)
- iB  in  WIDTH  rt operand (multiplier / divisor)
- iWrHi  in  1  MTHI write strobe
- iWrLo  in  1  MTLO write strobe
- iWrData  in  WIDTH  MTHI/MTLO data
- oHi  out  WIDTH  HI register
- oLo  out  WIDTH  LO register
- oBusy  out  1  operation in flight; pipeline stalls on mult/div/mfhi/mflo while high
- oDone  out  1  one-cycle pulse when HI/LO are updated by an operation
- oDivZero  out  1  one-cycle pulse alongside oDone when the divisor was zero

Behaviour:
- Reset (iRSTn low at a rising edge):
  - oHi = 0, oLo = 0, oBusy = 0, oDone = 0, oDivZero = 0.
  - FSM goes to IDLE; counter and all working registers are cleared.
  - Reset mid-operation aborts the operation; HI/LO read 0 afterwards.
- FSM states: IDLE, CALC, FIX.
- IDLE:
  - If iStart is sampled high at edge N, the unit latches iOp, the sign flags, |iA| and |iB| (absolute value only for signed ops), and clears the counter.
  - Next state is CALC. oBusy goes high after edge N.
- CALC: 32 iterations, one per edge (N+1..N+32).
  - Multiply: shift-add over a 64-bit accumulator {P_hi, P_lo}.
  - Divide: restoring shift-subtract. Remainder register is 33 bits (guards the borrow); quotient shifts into the low word.
  - Transition to FIX after the counter reaches WIDTH-1.
- FIX: single edge N+33.
  - Signed multiply: negate the 64-bit product if the operand signs differ.
  - Signed divide: negate the quotient if the signs differ; the remainder takes the sign of the dividend.
  - Write HI/LO: multiply gives HI = product[63:32], LO = product[31:0]; divide gives LO = quotient, HI = remainder.
  - Next state is IDLE.
  - oBusy is 0 and oDone is 1 for the single cycle after edge N+33.
- Total latency: 34 edges from the start edge to the HI/LO update.
- Divide by zero (iB == 0 at start):
  - Skip CALC and go IDLE -> FIX.
  - HI/LO are left unchanged. oDone and oDivZero pulse together.
  - Latency is 2 edges.
- Overflow: signed DIV of 0x80000000 by 0xFFFFFFFF gives LO = 0x80000000, HI = 0. No flag; this is the natural 2's-complement wrap.
- iStart while oBusy is high is ignored (no queueing).
- iWrHi/iWrLo:
  - Honoured only in IDLE; write iWrData on the edge; ignored while busy.
  - If iWrHi/iWrLo and iStart are both high in IDLE, the write takes effect now and the operation result overwrites it at FIX.
- oHi/oLo are registered outputs. They hold their previous values throughout CALC; no intermediate values are visible.

Optional Feature:
- Macro: MDU_FAST_MULT_EN.
- Defined:
  - MULT/MULTU use a combinational WIDTHxWIDTH signed/unsigned product.
  - The product is registered in FIX on the edge after start (latency 2); CALC is skipped for multiplies.
  - Divide behaviour is unchanged.
- Undefined:
  - All operations use the iterative datapath, as described in Behaviour.

Test Plan:
- Reset then idle: iRSTn=0 for 2 cycles -> oHi = oLo = 0, oBusy = 0, oDone = 0.
- MULT A=0xFFFFFFFE (-2), B=0x00000003 -> after 34 edges HI = 0xFFFFFFFF, LO = 0xFFFFFFFA. oBusy is high for 33 cycles; oDone pulses once.
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> HI = 0xFFFFFFFE, LO = 0x00000001.
- DIV A=0xFFFFFFF9 (-7), B=0x00000002 -> LO = 0xFFFFFFFD (-3), HI = 0xFFFFFFFF (-1). DIVU 100/7 -> LO = 14, HI = 2.
- Divide by zero: MTHI 0x1234, MTLO 0x5678, then DIV A=5, B=0 -> oDone and oDivZero pulse 2 edges after start; HI = 0x1234, LO = 0x5678 unchanged.
- Collision and abort:
  - iStart with new operands while busy -> ignored; the first result is intact.
  - iWrLo while busy -> LO is unaffected.
  - iRSTn low at cycle 10 of a DIV -> IDLE, HI = LO = 0, no oDone.
